cmult_sequencer: RTL

CMULT_SEQUENCER -- requirements
Module: cmult_sequencer

---
 rtl/cmult_sequencer_pkg.sv | 16 +
 rtl/cmult_sequencer_if.sv | 30 +++
 rtl/cmult_sequencer_sign_mult.sv | 19 +
 rtl/cmult_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cmult_sequencer_pkg.sv
// Shared fixed-point defaults and sequencer state encoding for the FFT butterfly blocks.
package fft_pkg;

  localparam int WORD_MID_DEF  = 16;
  localparam int FRAC_BITS_DEF = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    DONE = 3'd5
  } cmult_state_e;

endpackage

// File: rtl/cmult_sequencer_if.sv
// Operand/result handshake bundle between a producer (master) and the complex multiplier (slave).
interface cmult_sequencer_if
  import fft_pkg::*;
#(
  parameter int WORD_MID = WORD_MID_DEF
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic signed [WORD_MID-1:0] ar;
  logic signed [WORD_MID-1:0] ai;
  logic signed [WORD_MID-1:0] br;
  logic signed [WORD_MID-1:0] bi;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [WORD_MID-1:0] cr;
  logic signed [WORD_MID-1:0] ci;
  logic                       busy;

  modport master (
    output in_valid, ar, ai, br, bi, out_ready,
    input  in_ready, out_valid, cr, ci, busy
  );

  modport slave (
    input  in_valid, ar, ai, br, bi, out_ready,
    output in_ready, out_valid, cr, ci, busy
  );

endinterface

// File: rtl/cmult_sequencer_sign_mult.sv
// Combinational signed fixed-point multiplier: full product, floor shift by FRAC_BITS, wrap to WORD_MID.
module sign_mult
  import fft_pkg::*;
#(
  parameter int WORD_MID  = WORD_MID_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic signed [WORD_MID-1:0] i_a,
  input  logic signed [WORD_MID-1:0] i_b,
  output logic signed [WORD_MID-1:0] o_p
);

  logic signed [2*WORD_MID-1:0] w_full;

  assign w_full = i_a * i_b;
  // Arithmetic shift gives floor toward -inf; upper bits are simply dropped (wrap).
  assign o_p    = WORD_MID'(w_full >>> FRAC_BITS);

endmodule

// File: rtl/cmult_sequencer.sv
// Complex multiplier C = A*B built around one shared sign_mult, stepped over four product cycles.
module cmult_sequencer
  import fft_pkg::*;
#(
  parameter int WORD_MID  = WORD_MID_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  cmult_sequencer_if.slave bus
);

  cmult_state_e               r_state;
  logic signed [WORD_MID-1:0] r_ar;
  logic signed [WORD_MID-1:0] r_ai;
  logic signed [WORD_MID-1:0] r_br;
  logic signed [WORD_MID-1:0] r_bi;
  logic signed [WORD_MID-1:0] r_acc_r;
  logic signed [WORD_MID-1:0] r_acc_i;
  logic signed [WORD_MID-1:0] r_cr;
  logic signed [WORD_MID-1:0] r_ci;
  logic                       r_out_valid;
  logic                       r_busy;

  logic signed [WORD_MID-1:0] w_mul_a;
  logic signed [WORD_MID-1:0] w_mul_b;
  logic signed [WORD_MID-1:0] w_prod;

  // Operand pairing per phase: P0 ar*br, P1 ai*bi, P2 ar*bi, P3 ai*br.
  always_comb begin
    w_mul_a = r_ar;
    w_mul_b = r_br;
    case (r_state)
      P1: begin
        w_mul_a = r_ai;
        w_mul_b = r_bi;
      end
      P2: begin
        w_mul_a = r_ar;
        w_mul_b = r_bi;
      end
      P3: begin
        w_mul_a = r_ai;
        w_mul_b = r_br;
      end
      default: begin
        w_mul_a = r_ar;
        w_mul_b = r_br;
      end
    endcase
  end

  sign_mult #(
    .WORD_MID  (WORD_MID),
    .FRAC_BITS (FRAC_BITS)
  ) u_sign_mult (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_ar        <= '0;
      r_ai        <= '0;
      r_br        <= '0;
      r_bi        <= '0;
      r_acc_r     <= '0;
      r_acc_i     <= '0;
      r_cr        <= '0;
      r_ci        <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_ar    <= bus.ar;
            r_ai    <= bus.ai;
            r_br    <= bus.br;
            r_bi    <= bus.bi;
            r_busy  <= 1'b1;
            r_state <= P0;
          end
        end
        P0: begin
          r_acc_r <= w_prod;
          r_state <= P1;
        end
        P1: begin
          r_acc_r <= r_acc_r - w_prod;
          r_state <= P2;
        end
        P2: begin
          r_acc_i <= w_prod;
          r_state <= P3;
        end
        P3: begin
          // Result registers load only here so cr/ci hold steady until the next product lands.
          r_acc_i     <= r_acc_i + w_prod;
          r_cr        <= r_acc_r;
          r_ci        <= r_acc_i + w_prod;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.cr        = r_cr;
  assign bus.ci        = r_ci;

endmodule
